// File: rtl/full_adder_if.sv
// Bit-slice bus for the full adder: operand/qualifier inputs plus combinational
// and registered results. The slave modport is the adder side.
interface full_adder_if;
    logic a;
    logic b;
    logic cin;
    logic in_valid;
    logic s;
    logic cout;
    logic s_q;
    logic cout_q;
    logic out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  s, cout, s_q, cout_q, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output s, cout, s_q, cout_q, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// 1-bit mirror-topology full adder with a combinational result and a one-stage
// registered copy qualified by a valid flag; used as the ripple-adder bit-slice.
module full_adder (
    input  logic          clk,
    input  logic          rst,
    full_adder_if.slave   bus
);

    logic ab_and;
    logic ab_or;
    logic abc_and;
    logic abc_or;
    logic cout_n;
    logic s_n;
    logic cout_c;
    logic s_c;

    logic sum_q,   sum_d;
    logic carry_q, carry_d;
    logic valid_q, valid_d;

    assign ab_and  = bus.a & bus.b;
    assign ab_or   = bus.a | bus.b;
    assign abc_and = ab_and & bus.cin;
    assign abc_or  = ab_or | bus.cin;

    // Carry-bar first; the sum-bar stage reuses it instead of an XOR chain.
    assign cout_n = ~(ab_and | (bus.cin & ab_or));
    assign s_n    = ~(abc_and | (cout_n & abc_or));

    assign cout_c = ~cout_n;
    assign s_c    = ~s_n;

    assign bus.cout = cout_c;
    assign bus.s    = s_c;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            sum_d   = s_c;
            carry_d = cout_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.s_q       = sum_q;
    assign bus.cout_q    = carry_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: directed comb/reset/pipeline checks, then randomized
// traffic with a scoreboard queue drained by an independent monitor.
module tb_full_adder;

    logic clk;
    logic rst;
    full_adder_if bus_if ();

    full_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] held;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the 2-bit arithmetic sum of three bits.
    function automatic logic [1:0] ref_sum(input logic a, input logic b, input logic c);
        int t;
        t = int'(a) + int'(b) + int'(c);
        return t[1:0];
    endfunction

    // Monitor: consumes the scoreboard whenever the registered result is valid,
    // otherwise requires the registered result to hold.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (bus_if.out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_valid", {3'b0, bus_if.out_valid}, 4'b0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_result", {2'b0, bus_if.cout_q, bus_if.s_q}, {2'b0, e});
                        held = e;
                    end
                end else begin
                    check("sb_hold", {2'b0, bus_if.cout_q, bus_if.s_q}, {2'b0, held});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v;
        logic ra, rb, rc, rv;

        rst = 1'b1;
        bus_if.a = 1'b0;
        bus_if.b = 1'b0;
        bus_if.cin = 1'b0;
        bus_if.in_valid = 1'b0;
        #1;
        check("reset_state", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0000);

        @(negedge clk);
        rst = 1'b0;

        // Exhaustive combinational sweep.
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            bus_if.a = v[2];
            bus_if.b = v[1];
            bus_if.cin = v[0];
            #1;
            check("comb_sum", {2'b0, bus_if.cout, bus_if.s}, {2'b0, ref_sum(v[2], v[1], v[0])});
        end

        bus_if.a = 1'b1; bus_if.b = 1'b1; bus_if.cin = 1'b0;
        #1;
        check("nodes_110", {2'b0, dut.cout_n, dut.s_n}, 4'b0001);
        bus_if.a = 1'b0; bus_if.b = 1'b0; bus_if.cin = 1'b1;
        #1;
        check("nodes_001", {2'b0, dut.cout_n, dut.s_n}, 4'b0010);

        // Asynchronous reset between edges.
        @(negedge clk);
        bus_if.a = 1'b1; bus_if.b = 1'b1; bus_if.cin = 1'b1; bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("capture_111", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_overrides_valid", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_capture_after_reset", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0111);

        // Pipeline capture then hold.
        @(negedge clk);
        bus_if.a = 1'b1; bus_if.b = 1'b0; bus_if.cin = 1'b1; bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pipe_capture", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0110);
        @(negedge clk);
        bus_if.a = 1'b0; bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pipe_hold", {1'b0, bus_if.out_valid, bus_if.cout_q, bus_if.s_q}, 4'b0010);

        // Randomized traffic through the scoreboard.
        @(negedge clk);
        held = 2'b10;
        exp_q.delete();
        mon_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            bus_if.a = ra;
            bus_if.b = rb;
            bus_if.cin = rc;
            bus_if.in_valid = rv;
            if (rv) exp_q.push_back(ref_sum(ra, rb, rc));
            #1;
            check("rand_comb", {2'b0, bus_if.cout, bus_if.s}, {2'b0, ref_sum(ra, rb, rc)});
            @(negedge clk);
        end
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("sb_drained", exp_q.size() == 0 ? 4'b0001 : 4'b0000, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
